mxint_block_quantizer: RTL and testbench

Streaming, parametrised MX-integer block quantizer: accepts float32 elements one per cycle on a valid/ready stream, buffers a block of BLOCK_SIZE, derives the shared E8M0 scale from the largest exponent, quantizes each element serially to a signed ELEM_WIDTH fixed-point value, and presents the whole block on a valid/ready output. It is the sequential successor to the combinational mxint8 broadcast block, and sits between the float32 datapath and MX-format storage and compute. A broadcast mode preserves the old single-scalar behaviour.

---
 rtl/mx_pkg.sv | 28 ++
 rtl/mxint_block_quantizer_if.sv | 33 +++
 rtl/mxint_elem_quant.sv | 58 +++++
 rtl/mxint_block_quantizer.sv | 146 ++++++++++++++
 tb/tb_mxint_block_quantizer.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mx_pkg.sv
// Shared definitions for the MX-integer quantizer family: float32 field
// layout, E8M0 special codes and the block FSM state encoding.
package mx_pkg;

    localparam int FLOAT32_WIDTH = 32;
    localparam int EXP_WIDTH     = 8;
    localparam int FRAC_WIDTH    = 23;
    localparam int MANT_WIDTH    = FRAC_WIDTH + 1;  // significand with hidden one

    // Exponent field value reserved for Inf/NaN in binary32.
    localparam logic [EXP_WIDTH-1:0] EXP_SPECIAL = 8'hFF;
    // E8M0 code reserved for NaN; otherwise E8M0 shares the binary32 bias of
    // 127, so a float exponent field maps onto a scale code unchanged.
    localparam logic [7:0] E8M0_NAN = 8'hFF;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_QUANT,
        ST_OUT
    } state_t;

    typedef struct packed {
        logic                  sign;
        logic [EXP_WIDTH-1:0]  exp;
        logic [FRAC_WIDTH-1:0] frac;
    } float32_t;

endpackage

// File: rtl/mxint_block_quantizer_if.sv
// Stream bundle for the block quantizer: float32 elements in, one quantized
// MX block (shared scale + packed elements) out.
interface mxint_block_quantizer_if
    import mx_pkg::*;
#(
    parameter int BLOCK_SIZE  = 32,
    parameter int ELEM_WIDTH  = 8,
    parameter int SCALE_WIDTH = 8
);

    logic                             i_valid;
    logic                             o_ready;
    logic [FLOAT32_WIDTH-1:0]         i_float32;
    logic                             i_broadcast;
    logic                             o_valid;
    logic                             i_ready;
    logic [SCALE_WIDTH-1:0]           o_scale;
    logic [BLOCK_SIZE*ELEM_WIDTH-1:0] o_elements;
    logic                             o_overflow;

    // Producer/consumer side of the quantizer.
    modport master (
        output i_valid, i_float32, i_broadcast, i_ready,
        input  o_ready, o_valid, o_scale, o_elements, o_overflow
    );

    // The quantizer itself.
    modport slave (
        input  i_valid, i_float32, i_broadcast, i_ready,
        output o_ready, o_valid, o_scale, o_elements, o_overflow
    );

endinterface

// File: rtl/mxint_elem_quant.sv
// Combinational single-element MX-int quantizer. Aligns one float32 to the
// block's largest exponent, rounds to nearest-even at FB = ELEM_WIDTH-2
// fraction bits, applies the sign and clamps symmetrically.
// Assumes ELEM_WIDTH-2 <= 23 so the base alignment is a right shift.
module mxint_elem_quant
    import mx_pkg::*;
#(
    parameter int ELEM_WIDTH = 8
) (
    input  float32_t              value,
    input  logic [EXP_WIDTH-1:0]  emax,
    output logic [ELEM_WIDTH-1:0] element,
    output logic                  saturated
);

    localparam int FB          = ELEM_WIDTH - 2;
    localparam int BASE_SHIFT  = FRAC_WIDTH - FB;      // shift for the emax element
    localparam int FLUSH_SHIFT = MANT_WIDTH + 1;       // at or beyond this, result is 0
    localparam int PAD         = FLUSH_SHIFT + 1;      // guard + sticky bits kept exactly
    localparam int WIDE        = MANT_WIDTH + PAD;
    localparam int MAG_W       = MANT_WIDTH + 1;       // room for the round-up carry
    localparam int SH_W        = $clog2(FLUSH_SHIFT + 1);
    localparam logic [MAG_W-1:0] Q_MAX = MAG_W'((1 << (ELEM_WIDTH - 1)) - 1);

    logic [MANT_WIDTH-1:0] mant;
    logic [EXP_WIDTH:0]    diff;
    logic [9:0]            total;
    logic [SH_W-1:0]       sh;
    logic [WIDE-1:0]       wide;
    logic [MANT_WIDTH-1:0] int_part;
    logic                  guard;
    logic                  sticky;
    logic                  round_up;
    logic [MAG_W-1:0]      mag;
    logic [MAG_W-1:0]      clamped;

    // Align, round to nearest-even, flush zero/subnormal, clamp and sign.
    // NOTE: every output of this always_comb is assigned on every path, so no latch.
    always_comb begin
        mant     = {1'b1, value.frac};
        diff     = {1'b0, emax} - {1'b0, value.exp};
        total    = 10'(BASE_SHIFT) + {1'b0, diff};
        sh       = (total > 10'(FLUSH_SHIFT)) ? SH_W'(FLUSH_SHIFT) : SH_W'(total);
        wide     = {mant, {PAD{1'b0}}} >> sh;
        int_part = wide[WIDE-1:PAD];
        guard    = wide[PAD-1];
        sticky   = |wide[PAD-2:0];
        round_up = guard & (sticky | int_part[0]);
        mag      = {1'b0, int_part} + MAG_W'(round_up);
        if (value.exp == '0) begin
            mag = '0;
        end
        saturated = (mag > Q_MAX);
        clamped   = saturated ? Q_MAX : mag;
        element   = value.sign ? ELEM_WIDTH'(MAG_W'(0) - clamped) : ELEM_WIDTH'(clamped);
    end

endmodule

// File: rtl/mxint_block_quantizer.sv
// Streaming MX-int block quantizer: collects BLOCK_SIZE float32 elements (or
// one broadcast element), derives the shared E8M0 scale from the largest
// exponent, quantizes one element per cycle and holds the finished block
// until the consumer takes it.
module mxint_block_quantizer
    import mx_pkg::*;
#(
    parameter int BLOCK_SIZE  = 32,
    parameter int ELEM_WIDTH  = 8,
    parameter int SCALE_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mxint_block_quantizer_if.slave  bus
);

    localparam int CNT_W = $clog2(BLOCK_SIZE);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_SIZE - 1);

    state_t                           state;
    state_t                           state_next;
    float32_t                         buffer [BLOCK_SIZE];
    logic [CNT_W-1:0]                 cnt;
    logic [CNT_W-1:0]                 idx;
    logic [EXP_WIDTH-1:0]             emax;
    logic                             nan;
    logic                             bcast;
    logic [SCALE_WIDTH-1:0]           scale;
    logic [BLOCK_SIZE*ELEM_WIDTH-1:0] elements;
    logic                             overflow;

    float32_t                         in_elem;
    float32_t                         cur_elem;
    logic [ELEM_WIDTH-1:0]            q_elem;
    logic                             q_sat;
    logic                             accept;
    logic                             release_blk;

    assign in_elem     = float32_t'(bus.i_float32);
    assign accept      = bus.i_valid && (state == ST_FILL);
    assign release_blk = (state == ST_OUT) && bus.i_ready;
    // A broadcast block stores only entry 0 and replays it for every index.
    assign cur_elem    = bcast ? buffer[0] : buffer[idx];

    mxint_elem_quant #(
        .ELEM_WIDTH (ELEM_WIDTH)
    ) u_elem_quant (
        .value     (cur_elem),
        .emax      (emax),
        .element   (q_elem),
        .saturated (q_sat)
    );

    // FSM state register.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FILL;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state: fill until the block is complete, quantize, then hold.
    always_comb begin
        state_next = state;
        case (state)
            ST_FILL: begin
                if (accept && ((bus.i_broadcast && cnt == '0) || cnt == LAST)) begin
                    state_next = ST_QUANT;
                end
            end
            ST_QUANT: begin
                if (idx == LAST) begin
                    state_next = ST_OUT;
                end
            end
            ST_OUT: begin
                if (bus.i_ready) begin
                    state_next = ST_FILL;
                end
            end
            default: state_next = ST_FILL;
        endcase
    end

    // Element buffer; contents are only read after being written this block.
    // NOTE: the buffer is deliberately not reset, so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (accept) begin
            buffer[cnt] <= in_elem;
        end
    end

    // Fill/quantize counters, running max exponent, NaN and broadcast flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            idx   <= '0;
            emax  <= '0;
            nan   <= 1'b0;
            bcast <= 1'b0;
        end else if (accept) begin
            cnt <= cnt + 1'b1;
            if (in_elem.exp > emax) begin
                emax <= in_elem.exp;
            end
            if (in_elem.exp == EXP_SPECIAL) begin
                nan <= 1'b1;
            end
            if (cnt == '0) begin
                bcast <= bus.i_broadcast;
            end
        end else if (state == ST_QUANT) begin
            idx <= idx + 1'b1;
        end else if (release_blk) begin
            cnt   <= '0;
            idx   <= '0;
            emax  <= '0;
            nan   <= 1'b0;
            bcast <= 1'b0;
        end
    end

    // Output block registers, written one element per QUANT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scale    <= '0;
            elements <= '0;
            overflow <= 1'b0;
        end else if (state == ST_QUANT) begin
            scale <= nan ? SCALE_WIDTH'(E8M0_NAN) : SCALE_WIDTH'(emax);
            elements[idx*ELEM_WIDTH +: ELEM_WIDTH] <= nan ? '0 : q_elem;
            overflow <= overflow | nan | q_sat;
        end else if (release_blk) begin
            overflow <= 1'b0;
        end
    end

    assign bus.o_ready    = (state == ST_FILL);
    assign bus.o_valid    = (state == ST_OUT);
    assign bus.o_scale    = scale;
    assign bus.o_elements = elements;
    assign bus.o_overflow = overflow;

endmodule

// File: tb/tb_mxint_block_quantizer.sv
// Self-checking bench for mxint_block_quantizer: directed blocks, a real-
// arithmetic reference model of the MX-int rules, a per-cycle output
// compare while o_valid is high, and hand-computed literal expectations.
module tb_mxint_block_quantizer;
    import mx_pkg::*;

    localparam int BS   = 32;
    localparam int EW   = 8;
    localparam int SW   = 8;
    localparam int FB   = EW - 2;
    localparam int QMAX = (1 << (EW - 1)) - 1;
    localparam int CW   = BS * EW;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mxint_block_quantizer_if #(.BLOCK_SIZE(BS), .ELEM_WIDTH(EW), .SCALE_WIDTH(SW)) bus ();

    mxint_block_quantizer #(
        .BLOCK_SIZE  (BS),
        .ELEM_WIDTH  (EW),
        .SCALE_WIDTH (SW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0]   blk [BS];
    logic [SW-1:0] exp_scale;
    logic [CW-1:0] exp_elems;
    logic          exp_ovf;

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [EW-1:0] elem_of(input logic [CW-1:0] v, input int i);
        return v[i*EW +: EW];
    endfunction

    // Reference: value = 1.frac * 2^(e-emax) * 2^FB, round half to even, clamp.
    function automatic int quant_ref(input logic [31:0] f, input int emax, output bit sat);
        int  e;
        int  q;
        real mag;
        real fl;
        e   = int'(f[30:23]);
        sat = 1'b0;
        if (e == 0) return 0;
        mag = real'(int'({1'b1, f[22:0]}));
        for (int j = 0; j < 23 - FB; j++) mag = mag / 2.0;
        for (int j = 0; j < emax - e; j++) mag = mag / 2.0;
        fl = $floor(mag);
        q  = $rtoi(fl);
        if ((mag - fl > 0.5) || (mag - fl == 0.5 && (q % 2) == 1)) q++;
        if (q > QMAX) begin
            q   = QMAX;
            sat = 1'b1;
        end
        return f[31] ? -q : q;
    endfunction

    task automatic build_model(input bit bcast);
        int          emax = 0;
        bit          nan  = 1'b0;
        bit          ovf  = 1'b0;
        bit          s;
        int          q;
        logic [31:0] f;
        for (int i = 0; i < BS; i++) begin
            f = bcast ? blk[0] : blk[i];
            if (f[30:23] == 8'hFF) nan = 1'b1;
            if (int'(f[30:23]) > emax) emax = int'(f[30:23]);
        end
        for (int i = 0; i < BS; i++) begin
            f = bcast ? blk[0] : blk[i];
            q = quant_ref(f, emax, s);
            ovf = ovf | s;
            exp_elems[i*EW +: EW] = EW'(q);
        end
        if (nan) begin
            exp_scale = 8'hFF;
            exp_elems = '0;
            exp_ovf   = 1'b1;
        end else begin
            exp_scale = SW'(emax);
            exp_ovf   = ovf;
        end
    endtask

    // Compare process: every cycle the block is presented it must match the model.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.o_valid === 1'b1) begin
            check("scale", CW'(bus.o_scale), CW'(exp_scale));
            check("elements", bus.o_elements, exp_elems);
            check("overflow", CW'(bus.o_overflow), CW'(exp_ovf));
            check("ready_in_out", CW'(bus.o_ready), CW'(1'b0));
        end
    end

    // Drive one block (1 element if broadcast), then wait for o_valid and check latency.
    task automatic send_block(input bit bcast, input bit bcast_late);
        int n;
        int k;
        n = bcast ? 1 : BS;
        k = 0;
        while (bus.o_ready !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        for (int i = 0; i < n; i++) begin
            check("ready_in_fill", CW'(bus.o_ready), CW'(1'b1));
            bus.i_valid     = 1'b1;
            bus.i_float32   = blk[i];
            bus.i_broadcast = (i == 0) ? bcast : bcast_late;
            @(negedge clk);
        end
        bus.i_valid     = 1'b0;
        bus.i_broadcast = 1'b0;
        k = 1;
        while (bus.o_valid !== 1'b1 && k < BS + 50) begin
            check("ready_in_quant", CW'(bus.o_ready), CW'(1'b0));
            @(negedge clk);
            k++;
        end
        check("latency", CW'(k), CW'(BS + 1));
    endtask

    // Hold off the consumer for 'stall' cycles while offering junk input, then take the block.
    task automatic take_block(input int stall);
        bus.i_valid   = 1'b1;
        bus.i_float32 = 32'h7F80_0000;
        repeat (stall) @(negedge clk);
        bus.i_ready = 1'b1;
        @(negedge clk);
        bus.i_ready = 1'b0;
        bus.i_valid = 1'b0;
        check("valid_after_hs", CW'(bus.o_valid), CW'(1'b0));
        check("ready_after_hs", CW'(bus.o_ready), CW'(1'b1));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_o_ready"}, CW'(bus.o_ready), CW'(1'b1));
        check({tag, "_o_valid"}, CW'(bus.o_valid), CW'(1'b0));
        check({tag, "_o_scale"}, CW'(bus.o_scale), CW'(0));
        check({tag, "_o_elements"}, bus.o_elements, CW'(0));
        check({tag, "_o_overflow"}, CW'(bus.o_overflow), CW'(1'b0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n           = 1'b0;
        bus.i_valid     = 1'b0;
        bus.i_float32   = '0;
        bus.i_broadcast = 1'b0;
        bus.i_ready     = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Broadcast 1.0
        for (int i = 0; i < BS; i++) blk[i] = 32'h1234_5678;
        blk[0] = 32'h3F80_0000;
        build_model(1'b1);
        check("model_1p0_scale", CW'(exp_scale), CW'(8'h7F));
        check("model_1p0_elem", CW'(elem_of(exp_elems, 17)), CW'(8'h40));
        send_block(1'b1, 1'b0);
        check("bc1_scale", CW'(bus.o_scale), CW'(8'h7F));
        check("bc1_elem0", CW'(elem_of(bus.o_elements, 0)), CW'(8'h40));
        check("bc1_elem31", CW'(elem_of(bus.o_elements, 31)), CW'(8'h40));
        check("bc1_ovf", CW'(bus.o_overflow), CW'(1'b0));
        take_block(0);

        // Broadcast -3.0
        blk[0] = 32'hC040_0000;
        build_model(1'b1);
        send_block(1'b1, 1'b0);
        check("bcm3_scale", CW'(bus.o_scale), CW'(8'h80));
        check("bcm3_elem5", CW'(elem_of(bus.o_elements, 5)), CW'(8'hA0));
        take_block(2);

        // Stream 4.0, 1.0, 0.5, zeros; late i_broadcast must be ignored
        for (int i = 0; i < BS; i++) blk[i] = 32'h0000_0000;
        blk[0] = 32'h4080_0000;
        blk[1] = 32'h3F80_0000;
        blk[2] = 32'h3F00_0000;
        build_model(1'b0);
        send_block(1'b0, 1'b1);
        check("str_scale", CW'(bus.o_scale), CW'(8'h81));
        check("str_elem0", CW'(elem_of(bus.o_elements, 0)), CW'(8'd64));
        check("str_elem1", CW'(elem_of(bus.o_elements, 1)), CW'(8'd16));
        check("str_elem2", CW'(elem_of(bus.o_elements, 2)), CW'(8'd8));
        check("str_elem3", CW'(elem_of(bus.o_elements, 3)), CW'(8'd0));
        take_block(1);

        // Positive saturation
        for (int i = 0; i < BS; i++) blk[i] = 32'h0000_0000;
        blk[0] = 32'h3FFF_FFFF;
        build_model(1'b0);
        send_block(1'b0, 1'b0);
        check("satp_elem0", CW'(elem_of(bus.o_elements, 0)), CW'(8'h7F));
        check("satp_ovf", CW'(bus.o_overflow), CW'(1'b1));
        take_block(0);

        // Negative saturation (symmetric clamp)
        blk[0] = 32'hBFFF_FFFF;
        build_model(1'b0);
        send_block(1'b0, 1'b0);
        check("satn_elem0", CW'(elem_of(bus.o_elements, 0)), CW'(8'h81));
        check("satn_ovf", CW'(bus.o_overflow), CW'(1'b1));
        take_block(0);

        // Rounding ties, flush of subnormal / tiny values, negative zero
        for (int i = 0; i < BS; i++) blk[i] = 32'h3F00_0000;
        blk[0] = 32'h3F80_0000;
        blk[1] = 32'h3C80_0000;  // 2^-6        -> 1
        blk[2] = 32'h3C00_0000;  // 2^-7        -> 0.5 ties to 0
        blk[3] = 32'h3C40_0000;  // 1.5*2^-7    -> 0.75 rounds to 1
        blk[4] = 32'h3CC0_0000;  // 1.5*2^-6    -> 1.5 ties to 2
        blk[5] = 32'hBCC0_0000;  // -1.5*2^-6   -> -2
        blk[6] = 32'h0000_0001;  // subnormal   -> 0
        blk[7] = 32'h8000_0000;  // -0          -> 0
        blk[8] = 32'h3F7F_FFFF;  // just below 1 -> 64
        blk[9] = 32'h0100_0000;  // far below emax -> 0
        build_model(1'b0);
        check("model_tie_even", CW'(elem_of(exp_elems, 2)), CW'(8'h00));
        check("model_tie_odd", CW'(elem_of(exp_elems, 4)), CW'(8'h02));
        send_block(1'b0, 1'b0);
        check("rne_elem1", CW'(elem_of(bus.o_elements, 1)), CW'(8'h01));
        check("rne_elem2", CW'(elem_of(bus.o_elements, 2)), CW'(8'h00));
        check("rne_elem3", CW'(elem_of(bus.o_elements, 3)), CW'(8'h01));
        check("rne_elem5", CW'(elem_of(bus.o_elements, 5)), CW'(8'hFE));
        check("rne_elem8", CW'(elem_of(bus.o_elements, 8)), CW'(8'h40));
        check("rne_elem10", CW'(elem_of(bus.o_elements, 10)), CW'(8'h20));
        take_block(0);

        // NaN among finite values, consumer stalls 5 cycles
        for (int i = 0; i < BS; i++) blk[i] = 32'h3F80_0000 + (i << 19);
        blk[7] = 32'h7FC0_0000;
        build_model(1'b0);
        send_block(1'b0, 1'b0);
        check("nan_scale", CW'(bus.o_scale), CW'(8'hFF));
        check("nan_elements", bus.o_elements, CW'(0));
        check("nan_ovf", CW'(bus.o_overflow), CW'(1'b1));
        take_block(5);

        // Reset after 10 accepts (partial block holds NaN and large values)
        for (int i = 0; i < 10; i++) begin
            bus.i_valid   = 1'b1;
            bus.i_float32 = (i == 3) ? 32'h7FC0_0000 : 32'h4100_0000;
            @(negedge clk);
        end
        bus.i_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_values("midfill_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Fresh block after reset: no residue from the discarded partial block
        for (int i = 0; i < BS; i++) blk[i] = 32'h3F80_0000;
        blk[0] = 32'h4000_0000;
        build_model(1'b0);
        send_block(1'b0, 1'b0);
        check("fresh_scale", CW'(bus.o_scale), CW'(8'h80));
        check("fresh_elem0", CW'(elem_of(bus.o_elements, 0)), CW'(8'h40));
        check("fresh_elem1", CW'(elem_of(bus.o_elements, 1)), CW'(8'h20));
        check("fresh_ovf", CW'(bus.o_overflow), CW'(1'b0));
        take_block(0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
